// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path.
// Address/data widths are the same ones the register file itself uses.
package regfile_wb_arbiter_pkg;
    localparam int ARB_RR     = 0;
    localparam int ARB_FIXED  = 1;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bus plus the register-file write port.
// slave = arbiter side, master = requesters / register file side.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      wb_we;
    logic [ADDR_W-1:0]         wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic [IDW-1:0]            grant_id;
    logic                      conflict;

    modport slave (
        input  flush, req_valid, req_addr, req_data,
        output req_ready, wb_we, wb_addr, wb_data, grant_id, conflict
    );
    modport master (
        output flush, req_valid, req_addr, req_data,
        input  req_ready, wb_we, wb_addr, wb_data, grant_id, conflict
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational single-winner grant: round-robin starting after ptr, or
// fixed priority with index 0 highest. en=0 suppresses every grant.
import regfile_wb_arbiter_pkg::*;

module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int MODE    = ARB_RR,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               en,
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     idx,
    output logic               any
);
    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (MODE == ARB_FIXED) j = k;
                else                   j = (int'(ptr) + 1 + k) % NUM_REQ;
                if (!any && valid[j]) begin
                    gnt[j] = 1'b1;
                    idx    = IDW'(j);
                    any    = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write
// port; the winning beat is registered one cycle before it reaches A3/WD3.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W,
    parameter int ARB_MODE = ARB_RR
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     win;
    logic               acc;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .MODE(ARB_MODE)) u_arb (
        .en    (!bus.flush),
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .gnt   (gnt),
        .idx   (win),
        .any   (acc)
    );

    assign bus.req_ready = gnt;
    assign win_addr = bus.req_addr[win*ADDR_W +: ADDR_W];
    assign win_data = bus.req_data[win*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_we    <= 1'b0;
            bus.wb_addr  <= '0;
            bus.wb_data  <= '0;
            bus.grant_id <= '0;
            bus.conflict <= 1'b0;
            rr_ptr       <= IDW'(NUM_REQ - 1);
        end else begin
            bus.conflict <= ($countones(bus.req_valid) > 1) && !bus.flush;
            if (acc) begin
                // x0 beats still consume the slot and advance the pointer
                bus.wb_we    <= (win_addr != '0);
                bus.wb_addr  <= win_addr;
                bus.wb_data  <= win_data;
                bus.grant_id <= win;
                if (ARB_MODE == ARB_RR) rr_ptr <= win;
            end else begin
                bus.wb_we <= 1'b0;
            end
        end
    end
endmodule
